credit_rr_scheduler: RTL and testbench



---
 rtl/credit_rr_scheduler.sv | 110 +++++++++++
 tb/tb_credit_rr_scheduler.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/credit_rr_scheduler.sv
// rtl/credit_rr_scheduler.sv - round-robin grant of variable-size credits from a shared pool
// Pool mirrors free slots of a shared buffer; grants debit it, downstream returns credit it.
module credit_rr_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int CNT_WIDTH    = 8,
  parameter int INIT_CREDITS = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           init_i,
  input  logic [NUM_REQ-1:0]             req_i,
  input  logic [NUM_REQ*CNT_WIDTH-1:0]   req_amt_i,
  input  logic                           ret_valid_i,
  input  logic [CNT_WIDTH-1:0]           ret_amt_i,
  output logic [NUM_REQ-1:0]             gnt_o,
  output logic [$clog2(NUM_REQ)-1:0]     gnt_idx_o,
  output logic [CNT_WIDTH-1:0]           credits_o,
  output logic                           ovf_err_o
);

  localparam int IW = $clog2(NUM_REQ);
  localparam logic [CNT_WIDTH-1:0] INIT_C = CNT_WIDTH'(INIT_CREDITS);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_GRANT} state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] pool;
  logic [CNT_WIDTH-1:0] win_amt;
  logic [IW-1:0]        ptr;
  logic [IW-1:0]        pick;
  logic                 found;
  logic [IW:0]          idx;
  logic [NUM_REQ-1:0]   elig;
  logic [CNT_WIDTH:0]   sum;

  assign credits_o = pool;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = req_i[i] && (req_amt_i[i*CNT_WIDTH +: CNT_WIDTH] <= pool);
    end
  end

  // First eligible index at or after the pointer, wrapping around.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr} + (IW+1)'(k);
      if (idx >= (IW+1)'(NUM_REQ)) idx = idx - (IW+1)'(NUM_REQ);
      if (!found && elig[idx[IW-1:0]]) begin
        found = 1'b1;
        pick  = idx[IW-1:0];
      end
    end
  end

  // Net delta applied once; one spare bit holds any overshoot above the ceiling.
  always_comb begin
    sum = {1'b0, pool};
    if (state == ST_GRANT) sum = sum - {1'b0, win_amt};
    if (ret_valid_i)       sum = sum + {1'b0, ret_amt_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= ST_INIT;
      pool      <= '0;
      win_amt   <= '0;
      ptr       <= '0;
      gnt_o     <= '0;
      gnt_idx_o <= '0;
      ovf_err_o <= 1'b0;
    end else begin
      if (init_i || state == ST_INIT) begin
        pool      <= INIT_C;
        ovf_err_o <= 1'b0;
      end else if (sum > {1'b0, INIT_C}) begin
        pool      <= INIT_C;
        ovf_err_o <= 1'b1;
      end else begin
        pool <= sum[CNT_WIDTH-1:0];
      end

      case (state)
        ST_INIT: begin
          state <= ST_IDLE;
          gnt_o <= '0;
        end
        ST_IDLE: begin
          if (found) begin
            state     <= ST_GRANT;
            gnt_o     <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
            gnt_idx_o <= pick;
            win_amt   <= req_amt_i[int'(pick)*CNT_WIDTH +: CNT_WIDTH];
          end
        end
        ST_GRANT: begin
          state <= ST_IDLE;
          gnt_o <= '0;
          ptr   <= (gnt_idx_o == IW'(NUM_REQ-1)) ? '0 : gnt_idx_o + 1'b1;
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_credit_rr_scheduler.sv
// tb/tb_credit_rr_scheduler.sv - directed self-checking bench for credit_rr_scheduler
module tb_credit_rr_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] req_amt = '0;
  logic        ret_valid = 1'b0;
  logic [7:0]  ret_amt = '0;
  logic [3:0]  gnt;
  logic [1:0]  gnt_idx;
  logic [7:0]  credits;
  logic        ovf_err;

  int tests = 0;
  int fails = 0;

  credit_rr_scheduler #(.NUM_REQ(4), .CNT_WIDTH(8), .INIT_CREDITS(16)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .init_i     (init),
    .req_i      (req),
    .req_amt_i  (req_amt),
    .ret_valid_i(ret_valid),
    .ret_amt_i  (ret_amt),
    .gnt_o      (gnt),
    .gnt_idx_o  (gnt_idx),
    .credits_o  (credits),
    .ovf_err_o  (ovf_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    // reset state
    step(); step();
    chk("rst_gnt", gnt, 0);
    chk("rst_idx", gnt_idx, 0);
    chk("rst_credits", credits, 0);
    chk("rst_ovf", ovf_err, 0);

    // 1: release, one INIT cycle at 0 then 16
    rst_n = 1'b1;
    chk("t1_credits_init", credits, 0);
    step();
    chk("t1_credits_16", credits, 16);
    chk("t1_gnt0", gnt, 0);
    step();
    chk("t1_gnt1", gnt, 0);

    // 2: all request 2 credits, strict rotation every 2 cycles
    req = 4'b1111;
    req_amt = {8'd2, 8'd2, 8'd2, 8'd2};
    for (int k = 0; k < 8; k++) begin
      step();
      chk($sformatf("t2_gnt%0d", k), gnt, 32'(4'b0001 << (k % 4)));
      chk($sformatf("t2_idx%0d", k), gnt_idx, k % 4);
      chk($sformatf("t2_pre%0d", k), credits, 16 - 2*k);
      step();
      chk($sformatf("t2_gap%0d", k), gnt, 0);
      chk($sformatf("t2_post%0d", k), credits, 14 - 2*k);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t2_exhausted", gnt, 0);
    end
    req = '0;

    // 3: oversize request never granted, others not blocked
    init = 1'b1;
    step();
    init = 1'b0;
    chk("t3_reinit", credits, 16);
    req = 4'b0011;
    req_amt = {8'd0, 8'd0, 8'd4, 8'd20};
    step();
    chk("t3_gnt1", gnt, 4'b0010);
    chk("t3_idx1", gnt_idx, 1);
    step();
    chk("t3_credits12", credits, 12);
    req = 4'b0001;
    ret_valid = 1'b1;
    ret_amt = 8'd4;
    step();
    ret_valid = 1'b0;
    chk("t3_credits16", credits, 16);
    chk("t3_no_ovf", ovf_err, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t3_req0_blocked", gnt, 0);
    end

    // 4: grant exactly the pool while a return lands in the GRANT cycle
    req = 4'b1000;
    req_amt = {8'd13, 8'd0, 8'd0, 8'd0};
    step();
    chk("t4_gnt3", gnt, 4'b1000);
    step();
    chk("t4_credits3", credits, 3);
    req = 4'b0100;
    req_amt = {8'd0, 8'd3, 8'd0, 8'd0};
    step();
    chk("t4_gnt2", gnt, 4'b0100);
    chk("t4_idx2", gnt_idx, 2);
    req = '0;
    ret_valid = 1'b1;
    ret_amt = 8'd5;
    step();
    chk("t4_net_credits", credits, 5);
    chk("t4_no_ovf", ovf_err, 0);

    // 5: overflow saturates and sticks until init
    ret_amt = 8'd9;
    step();
    chk("t5_credits14", credits, 14);
    ret_amt = 8'd5;
    step();
    ret_valid = 1'b0;
    chk("t5_sat", credits, 16);
    chk("t5_ovf", ovf_err, 1);
    step(); step();
    chk("t5_ovf_sticky", ovf_err, 1);
    init = 1'b1;
    step();
    init = 1'b0;
    chk("t5_ovf_clr", ovf_err, 0);
    chk("t5_credits", credits, 16);

    // 6: init during GRANT keeps the pulse but discards the debit
    req = 4'b0001;
    req_amt = {8'd0, 8'd0, 8'd0, 8'd6};
    step();
    chk("t6_gnt0", gnt, 4'b0001);
    step();
    chk("t6_credits10", credits, 10);
    req = 4'b0010;
    req_amt = {8'd0, 8'd0, 8'd6, 8'd0};
    step();
    chk("t6_gnt1", gnt, 4'b0010);
    chk("t6_pre_init", credits, 10);
    req = '0;
    init = 1'b1;
    step();
    init = 1'b0;
    chk("t6_init_credits", credits, 16);
    chk("t6_gnt_done", gnt, 0);

    // 6b: asynchronous reset in the middle of a GRANT
    req = 4'b0100;
    req_amt = {8'd0, 8'd1, 8'd0, 8'd0};
    step();
    chk("t6b_gnt2", gnt, 4'b0100);
    rst_n = 1'b0;
    #1;
    chk("t6b_async_gnt", gnt, 0);
    chk("t6b_async_credits", credits, 0);
    step();
    rst_n = 1'b1;
    req = '0;
    chk("t6b_init_credits", credits, 0);
    step();
    chk("t6b_credits16", credits, 16);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
